// File: rtl/useq_pkg.sv
// Shared widths, FSM state type and slot-slice helper for the microcode loop sequencer.
package useq_pkg;

    localparam int DEF_UINST_ADDR_WIDTH = 8;
    localparam int DEF_LOOP_CNT_WIDTH   = 11;
    localparam int DEF_NUM_LOOPS        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } useq_state_t;

    // LSB position of a slot's field inside a flat per-slot vector.
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/useq_loop_sequencer_if.sv
// Control/decoder-facing bundle of the loop sequencer; master drives controls, slave is the sequencer.
interface useq_loop_sequencer_if
    import useq_pkg::*;
#(
    parameter int UINST_ADDR_WIDTH = DEF_UINST_ADDR_WIDTH,
    parameter int LOOP_CNT_WIDTH   = DEF_LOOP_CNT_WIDTH,
    parameter int NUM_LOOPS        = DEF_NUM_LOOPS,
    parameter int LOOP_ID_WIDTH    = $clog2(NUM_LOOPS)
);
    logic                                start_pos;
    logic [UINST_ADDR_WIDTH-1:0]         upc_start;
    logic                                done;
    logic                                stall;
    logic                                loop_st_vld;
    logic [LOOP_ID_WIDTH-1:0]            loop_st_id;
    logic [NUM_LOOPS*LOOP_CNT_WIDTH-1:0] loop_cnt_init;
    logic                                loop_end_vld;
    logic [LOOP_ID_WIDTH-1:0]            loop_end_id;
    logic                                jmp_vld;
    logic [UINST_ADDR_WIDTH-1:0]         jmp_addr;
    logic [UINST_ADDR_WIDTH-1:0]         upc;
    logic                                busy;
    logic [NUM_LOOPS*LOOP_CNT_WIDTH-1:0] loop_iter;
    logic                                loop_err;

    modport master (
        output start_pos, upc_start, done, stall, loop_st_vld, loop_st_id,
               loop_cnt_init, loop_end_vld, loop_end_id, jmp_vld, jmp_addr,
        input  upc, busy, loop_iter, loop_err
    );

    modport slave (
        input  start_pos, upc_start, done, stall, loop_st_vld, loop_st_id,
               loop_cnt_init, loop_end_vld, loop_end_id, jmp_vld, jmp_addr,
        output upc, busy, loop_iter, loop_err
    );
endinterface

// File: rtl/useq_loop_slot.sv
// One hardware loop slot: armed flag, body base address, remaining trip count and iteration index.
module useq_loop_slot
    import useq_pkg::*;
#(
    parameter int ADDR_W = DEF_UINST_ADDR_WIDTH,
    parameter int CNT_W  = DEF_LOOP_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              st,
    input  logic              end_hit,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [CNT_W-1:0]  cnt_init,
    output logic              armed,
    output logic              take,
    output logic [ADDR_W-1:0] base,
    output logic [CNT_W-1:0]  iter
);
    logic [CNT_W-1:0] remaining;

    // A count of 0 or 1 never branches back, so the body always runs at least once.
    assign take = end_hit && armed && (remaining > CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            armed     <= 1'b0;
            base      <= '0;
            remaining <= '0;
            iter      <= '0;
        end else if (st) begin
            armed     <= 1'b1;
            base      <= base_in;
            remaining <= cnt_init;
            iter      <= '0;
        end else if (end_hit && armed) begin
            if (take) begin
                remaining <= remaining - CNT_W'(1);
                iter      <= iter + CNT_W'(1);
            end else begin
                armed     <= 1'b0;
                remaining <= '0;
            end
        end
    end
endmodule

// File: rtl/useq_loop_sequencer.sv
// Microcode PC sequencer: IDLE/RUN FSM, per-slot hardware loops, jump, stall and sticky loop error.
module useq_loop_sequencer
    import useq_pkg::*;
#(
    parameter int UINST_ADDR_WIDTH = DEF_UINST_ADDR_WIDTH,
    parameter int LOOP_CNT_WIDTH   = DEF_LOOP_CNT_WIDTH,
    parameter int NUM_LOOPS        = DEF_NUM_LOOPS,
    parameter int LOOP_ID_WIDTH    = $clog2(NUM_LOOPS)
) (
    input logic                   clk,
    input logic                   rst,
    useq_loop_sequencer_if.slave  bus
);
    useq_state_t                 state, state_nxt;
    logic [UINST_ADDR_WIDTH-1:0] upc_r, upc_nxt, upc_inc;
    logic                        err_r, err_nxt;
    logic                        active, clr, same_id, end_ok;

    logic [NUM_LOOPS-1:0]        armed_vec, take_vec;
    logic [UINST_ADDR_WIDTH-1:0] slot_base [NUM_LOOPS];
    logic [LOOP_CNT_WIDTH-1:0]   slot_iter [NUM_LOOPS];
    logic [NUM_LOOPS*LOOP_CNT_WIDTH-1:0] iter_flat;

    assign upc_inc = upc_r + UINST_ADDR_WIDTH'(1);
    assign active  = (state == RUN) && !bus.start_pos && !bus.done && !bus.stall;
    assign clr     = bus.start_pos || ((state == RUN) && bus.done);
    // A start and end on the same slot in one cycle: the start owns the slot.
    assign same_id = bus.loop_st_vld && bus.loop_end_vld && (bus.loop_st_id == bus.loop_end_id);
    assign end_ok  = active && bus.loop_end_vld && !same_id;

    for (genvar k = 0; k < NUM_LOOPS; k++) begin : g_slot
        useq_loop_slot #(
            .ADDR_W (UINST_ADDR_WIDTH),
            .CNT_W  (LOOP_CNT_WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .st       (active && bus.loop_st_vld && (bus.loop_st_id == LOOP_ID_WIDTH'(k))),
            .end_hit  (end_ok && (bus.loop_end_id == LOOP_ID_WIDTH'(k))),
            .base_in  (upc_inc),
            .cnt_init (bus.loop_cnt_init[slot_lsb(k, LOOP_CNT_WIDTH) +: LOOP_CNT_WIDTH]),
            .armed    (armed_vec[k]),
            .take     (take_vec[k]),
            .base     (slot_base[k]),
            .iter     (slot_iter[k])
        );
    end

    always_comb begin
        iter_flat = '0;
        for (int k = 0; k < NUM_LOOPS; k++) begin
            iter_flat[k*LOOP_CNT_WIDTH +: LOOP_CNT_WIDTH] = slot_iter[k];
        end
    end

    // Next-state and next-upc selection; a taken loop end outranks a jump.
    always_comb begin
        state_nxt = state;
        upc_nxt   = upc_r;
        err_nxt   = err_r;
        if (bus.start_pos) begin
            state_nxt = RUN;
            upc_nxt   = bus.upc_start;
            err_nxt   = 1'b0;
        end else if (state == RUN) begin
            if (bus.done) begin
                state_nxt = IDLE;
                upc_nxt   = '0;
            end else if (!bus.stall) begin
                if (end_ok && !armed_vec[bus.loop_end_id]) begin
                    err_nxt = 1'b1;
                end
                if (|take_vec) begin
                    upc_nxt = slot_base[bus.loop_end_id];
                end else if (bus.jmp_vld) begin
                    upc_nxt = bus.jmp_addr;
                end else begin
                    upc_nxt = upc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            upc_r <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            upc_r <= upc_nxt;
            err_r <= err_nxt;
        end
    end

    assign bus.upc       = upc_r;
    assign bus.busy      = (state == RUN);
    assign bus.loop_iter = iter_flat;
    assign bus.loop_err  = err_r;
endmodule

// File: tb/tb_useq_loop_sequencer.sv
// Directed scoreboard bench for useq_loop_sequencer: driver queues expected state, negedge monitor compares.
module tb_useq_loop_sequencer;
    import useq_pkg::*;

    localparam int AW = 8;
    localparam int CW = 11;
    localparam int NL = 8;

    typedef struct packed {
        logic          rst;
        logic          start;
        logic [AW-1:0] ustart;
        logic          done;
        logic          stall;
        logic          stv;
        logic [2:0]    stid;
        logic          endv;
        logic [2:0]    endid;
        logic          jmp;
        logic [AW-1:0] jaddr;
    } ctrl_t;

    typedef struct {
        string         nm;
        int            cyc;
        logic [AW-1:0] upc;
        logic          busy;
        logic          err;
        int            slot;
        logic [CW-1:0] iter;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NL*CW-1:0] cntFlat = '0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t sb[$];

    useq_loop_sequencer_if bus ();

    useq_loop_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.loop_cnt_init = cntFlat;

    function automatic ctrl_t nop();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

    function automatic ctrl_t cRst();
        ctrl_t c;
        c = '0;
        c.rst = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cStart(input logic [AW-1:0] a);
        ctrl_t c;
        c = '0;
        c.start = 1'b1;
        c.ustart = a;
        return c;
    endfunction

    function automatic ctrl_t cDone();
        ctrl_t c;
        c = '0;
        c.done = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cLoopSt(input logic [2:0] id);
        ctrl_t c;
        c = '0;
        c.stv = 1'b1;
        c.stid = id;
        return c;
    endfunction

    function automatic ctrl_t cLoopEnd(input logic [2:0] id);
        ctrl_t c;
        c = '0;
        c.endv = 1'b1;
        c.endid = id;
        return c;
    endfunction

    function automatic ctrl_t cJmp(input logic [AW-1:0] a);
        ctrl_t c;
        c = '0;
        c.jmp = 1'b1;
        c.jaddr = a;
        return c;
    endfunction

    task automatic setCnt(input int k, input int v);
        cntFlat[k*CW +: CW] = CW'(v);
    endtask

    // Drive one cycle of controls and queue the state expected after the next edge.
    task automatic applyStimulus(input string nm, input ctrl_t c, input int eu, input bit eb,
                                 input bit ee, input int es, input int ei);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = c.rst;
        bus.start_pos    = c.start;
        bus.upc_start    = c.ustart;
        bus.done         = c.done;
        bus.stall        = c.stall;
        bus.loop_st_vld  = c.stv;
        bus.loop_st_id   = c.stid;
        bus.loop_end_vld = c.endv;
        bus.loop_end_id  = c.endid;
        bus.jmp_vld      = c.jmp;
        bus.jmp_addr     = c.jaddr;
        e.nm   = nm;
        e.cyc  = cyc + 1;
        e.upc  = AW'(eu);
        e.busy = eb;
        e.err  = ee;
        e.slot = es;
        e.iter = CW'(ei);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, req);
        end
    endtask

    // Monitor: pop whatever expectation is due this cycle and compare every output field.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                checkOutput({e.nm, ".stale"}, 32'(cyc), 32'(e.cyc));
            end else begin
                checkOutput({e.nm, ".upc"}, 32'(bus.upc), 32'(e.upc));
                checkOutput({e.nm, ".busy"}, 32'(bus.busy), 32'(e.busy));
                checkOutput({e.nm, ".err"}, 32'(bus.loop_err), 32'(e.err));
                checkOutput({e.nm, ".iter"}, 32'(bus.loop_iter[e.slot*CW +: CW]), 32'(e.iter));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ctrl_t c;
        bus.start_pos = 1'b0; bus.upc_start = '0; bus.done = 1'b0; bus.stall = 1'b0;
        bus.loop_st_vld = 1'b0; bus.loop_st_id = '0; bus.loop_end_vld = 1'b0;
        bus.loop_end_id = '0; bus.jmp_vld = 1'b0; bus.jmp_addr = '0;

        applyStimulus("reset0", cRst(), 'h00, 0, 0, 0, 0);
        applyStimulus("reset1", cRst(), 'h00, 0, 0, 0, 0);

        // Basic run and return to IDLE.
        applyStimulus("start10", cStart('h10), 'h10, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus("run", nop(), 'h10 + i, 1, 0, 0, 0);
        applyStimulus("done", cDone(), 'h00, 0, 0, 0, 0);
        applyStimulus("idleHold", nop(), 'h00, 0, 0, 0, 0);
        applyStimulus("idleJmp", cJmp('h55), 'h00, 0, 0, 0, 0);

        // Single loop on slot 2, count 3.
        setCnt(2, 3);
        applyStimulus("start20", cStart('h20), 'h20, 1, 0, 2, 0);
        applyStimulus("st2", cLoopSt(2), 'h21, 1, 0, 2, 0);
        for (int p = 0; p < 3; p++) begin
            applyStimulus("body22", nop(), 'h22, 1, 0, 2, p);
            applyStimulus("body23", nop(), 'h23, 1, 0, 2, p);
            applyStimulus("end2", cLoopEnd(2), (p < 2) ? 'h21 : 'h24, 1, 0, 2, (p < 2) ? p + 1 : 2);
        end

        // Nested loops: outer slot 0 x2, inner slot 1 x4.
        setCnt(0, 2);
        setCnt(1, 4);
        applyStimulus("start30", cStart('h30), 'h30, 1, 0, 0, 0);
        applyStimulus("st0", cLoopSt(0), 'h31, 1, 0, 0, 0);
        for (int o = 0; o < 2; o++) begin
            applyStimulus("st1", cLoopSt(1), 'h32, 1, 0, 1, 0);
            for (int j = 1; j <= 3; j++) applyStimulus("end1Take", cLoopEnd(1), 'h32, 1, 0, 1, j);
            applyStimulus("end1Fall", cLoopEnd(1), 'h33, 1, 0, 1, 3);
            applyStimulus("end0", cLoopEnd(0), (o == 0) ? 'h31 : 'h34, 1, 0, 0, 1);
        end

        // Zero and one trip counts.
        setCnt(3, 0);
        setCnt(4, 1);
        applyStimulus("start40", cStart('h40), 'h40, 1, 0, 3, 0);
        applyStimulus("st3", cLoopSt(3), 'h41, 1, 0, 3, 0);
        applyStimulus("end3Zero", cLoopEnd(3), 'h42, 1, 0, 3, 0);
        applyStimulus("st4", cLoopSt(4), 'h43, 1, 0, 4, 0);
        applyStimulus("end4One", cLoopEnd(4), 'h44, 1, 0, 4, 0);

        // Start and end together: same slot, then different slots.
        setCnt(2, 3);
        c = cLoopSt(2); c.endv = 1'b1; c.endid = 3'd2;
        applyStimulus("stEndSame", c, 'h45, 1, 0, 2, 0);
        applyStimulus("end2AfterSame", cLoopEnd(2), 'h45, 1, 0, 2, 1);
        c = cLoopSt(3); c.endv = 1'b1; c.endid = 3'd2;
        applyStimulus("stEndDiff", c, 'h45, 1, 0, 2, 2);
        applyStimulus("end2Fall", cLoopEnd(2), 'h46, 1, 0, 2, 2);
        applyStimulus("end3Armed", cLoopEnd(3), 'h47, 1, 0, 3, 0);

        // Stall freezes everything; branch beats jump; upc wraps.
        setCnt(2, 3);
        applyStimulus("start50", cStart('h50), 'h50, 1, 0, 2, 0);
        applyStimulus("st2b", cLoopSt(2), 'h51, 1, 0, 2, 0);
        applyStimulus("end2b", cLoopEnd(2), 'h51, 1, 0, 2, 1);
        for (int s = 0; s < 3; s++) begin
            c = cLoopEnd(2); c.stall = 1'b1; c.jmp = 1'b1; c.jaddr = 'h99;
            applyStimulus("stall", c, 'h51, 1, 0, 2, 1);
        end
        c = cLoopEnd(2); c.jmp = 1'b1; c.jaddr = 'hF0;
        applyStimulus("branchOverJmp", c, 'h51, 1, 0, 2, 2);
        applyStimulus("end2bFall", cLoopEnd(2), 'h52, 1, 0, 2, 2);
        applyStimulus("jmpFF", cJmp('hFF), 'hFF, 1, 0, 0, 0);
        applyStimulus("wrap", nop(), 'h00, 1, 0, 0, 0);
        applyStimulus("afterWrap", nop(), 'h01, 1, 0, 0, 0);

        // Error flag, restart, done with error held, reset mid-run.
        setCnt(6, 5);
        applyStimulus("end5Unarmed", cLoopEnd(5), 'h02, 1, 1, 0, 0);
        applyStimulus("errSticky", nop(), 'h03, 1, 1, 0, 0);
        applyStimulus("st6", cLoopSt(6), 'h04, 1, 1, 6, 0);
        applyStimulus("restart60", cStart('h60), 'h60, 1, 0, 6, 0);
        applyStimulus("end6Cleared", cLoopEnd(6), 'h61, 1, 1, 6, 0);
        applyStimulus("doneErrHeld", cDone(), 'h00, 0, 1, 0, 0);
        c = cStart('h80); c.done = 1'b1;
        applyStimulus("startIdle", c, 'h80, 1, 0, 0, 0);
        c = cStart('h70); c.done = 1'b1;
        applyStimulus("startDoneRun", c, 'h70, 1, 0, 0, 0);
        setCnt(7, 4);
        applyStimulus("st7", cLoopSt(7), 'h71, 1, 0, 7, 0);
        applyStimulus("end7", cLoopEnd(7), 'h71, 1, 0, 7, 1);
        c = cRst(); c.start = 1'b1; c.ustart = 'h44; c.jmp = 1'b1; c.jaddr = 'h33;
        applyStimulus("rstRun", c, 'h00, 0, 0, 7, 0);
        applyStimulus("postRst", nop(), 'h00, 0, 0, 7, 0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("scoreboardDrain", 32'(sb.size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
